product_accumulator: RTL and testbench
======================================

# product_accumulator

Downstream stage of the 16x16 multiplier: consumes the 32-bit unsigned products and sums a programmable-length run of them into one wide dot-product result. Valid/ready on both sides, so it can sit behind a registered or pipelined multiplier and ahead of any stalling consumer. One clock domain; all state is cleared by a synchronous active-low reset.

## Interface
- PROD_W, 32, product width; matches multiplier result width.
- ACC_W, 40, accumulator width; must be >= PROD_W.
- LEN_W, 8, width of vector-length field.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- prod_in  input  PROD_W  unsigned product from multiplier.
- prod_valid  input  1  prod_in valid this cycle.
- prod_ready  output  1  block accepts prod_in this cycle.
- vec_len  input  LEN_W  products per vector; sampled only with the first product of a vector; 0 treated as 1.
- acc_out  output  ACC_W  accumulated sum, held stable while acc_valid=1.
- acc_ovf  output  1  at least one add in this vector carried out of ACC_W; valid with acc_valid.
- acc_valid  output  1  acc_out/acc_ovf hold a completed vector.
- acc_ready  input  1  consumer takes result this cycle.

## Operation
- Accept = prod_valid & prod_ready; transfer out = acc_valid & acc_ready.
- FSM states: IDLE, ACCUM, HOLD. Reset state IDLE.
- IDLE: prod_ready=1, acc_valid=0. On accept: acc <= zero-extended prod_in, len_q <= max(vec_len,1), cnt <= 1, ovf <= 0; go HOLD if len_q==1, else ACCUM.
- ACCUM: prod_ready=1, acc_valid=0. On accept: acc <= acc + prod_in (ACC_W+1-bit sum), cnt <= cnt+1, ovf <= ovf | carry; go HOLD when cnt+1 == len_q. No accept: hold everything.
- HOLD: prod_ready=0, acc_valid=1, acc_out=acc, acc_ovf=ovf. On acc_ready: go IDLE. Otherwise stay; acc_out stable.
- cnt is LEN_W+1 bits so len_q = 2^LEN_W-1 completes without wrap.
- prod_in ignored whenever prod_valid=0 or prod_ready=0; no X propagation into acc.
- vec_len changes during ACCUM have no effect on the current vector.
- Reset mid-operation (any state): next edge FSM=IDLE, acc=0, cnt=0, ovf=0, all outputs at reset values; partial vector discarded.

## Timing
- Reset values: prod_ready=1 (IDLE, after first edge with rst_n=1 — during reset prod_ready=0), acc_valid=0, acc_out=0, acc_ovf=0.
- prod_ready and acc_valid are pure functions of the FSM state register (no combinational path from acc_ready or prod_valid).
- Throughput: one product per cycle inside a vector; one HOLD cycle minimum between vectors, so an N-product vector occupies >= N+1 cycles.
- Latency: acc_valid rises the cycle after the last product is accepted.
- acc_ready held low: HOLD persists indefinitely, prod_ready stays 0 (back-pressure to multiplier).
- acc_ready high before acc_valid: no effect.

## Configuration
- ACC_SATURATE_EN defined: on carry out of ACC_W, acc clamps to all-ones and stays clamped for the remainder of the vector; acc_ovf=1.
- ACC_SATURATE_EN undefined: sum wraps modulo 2^ACC_W; acc_ovf still flags the carry.
- Default build: undefined.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with prod_valid=1, prod_in=32'hFFFF_FFFF -> acc_valid=0, acc_out=0, prod_ready=0 throughout; IDLE after release.
- vec_len=4, products 3, 5, 7, 11 on consecutive cycles, acc_ready=1 -> acc_out=26, acc_ovf=0, acc_valid one cycle after 4th accept, for exactly 1 cycle.
- vec_len=0, single product 16'hFFFF*16'hFFFF = 32'hFFFE_0001 -> treated as length 1, acc_out=40'h00_FFFE_0001.
- vec_len=3 with prod_valid gaps (valid on cycles 0,2,5) and acc_ready low for 4 cycles after completion -> correct sum, acc_out stable, prod_ready=0 during stall.
- ACC_W=33, vec_len=3, three products 32'hFFFF_FFFF -> without macro acc_out=33'h0_FFFF_FFFD, acc_ovf=1; with ACC_SATURATE_EN acc_out=33'h1_FFFF_FFFF, acc_ovf=1.
- Reset asserted after 2 of 4 products, then new vec_len=2 vector 10, 20 -> acc_out=30, no residue from the aborted vector.

Source files
------------

// File: rtl/product_accumulator.sv
// ============================================================================
// product_accumulator
// ----------------------------------------------------------------------------
// Sits downstream of the 16x16 multiplier. It sums a run of unsigned
// products into one wide dot-product result. The run length is programmable
// per vector. Both sides use valid/ready handshakes, so the block can follow
// a registered or pipelined multiplier and feed a consumer that stalls.
//
// Parameters
//   PROD_W  product width (multiplier result width)
//   ACC_W   accumulator width, must be >= PROD_W
//   LEN_W   width of the vector-length field
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   prod_in     unsigned product from the multiplier
//   prod_valid  prod_in is valid this cycle
//   prod_ready  block accepts prod_in this cycle
//   vec_len     products per vector; sampled with the first product only.
//               A value of 0 is treated as 1.
//   acc_out     accumulated sum; held stable while acc_valid is high
//   acc_ovf     at least one add in this vector carried out of ACC_W
//   acc_valid   acc_out and acc_ovf hold a completed vector
//   acc_ready   consumer takes the result this cycle
//
// Build option
//   ACC_SATURATE_EN  When this macro is defined, a carry out of ACC_W clamps
//                    the accumulator to all-ones. When it is undefined (the
//                    default), the sum wraps modulo 2^ACC_W. In both cases
//                    acc_ovf flags the carry.
// ============================================================================
`default_nettype none

module product_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [LEN_W-1:0]  vec_len,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_ovf,
  output logic              acc_valid,
  input  logic              acc_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  // Low while reset is asserted, high from the first edge after release.
  // Keeps prod_ready low during reset without a combinational path from
  // rst_n.
  logic               run_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  // One bit wider than vec_len so that a length of 2^LEN_W-1 completes
  // without the counter wrapping.
  logic [LEN_W:0]     cnt_q, cnt_d;
  logic [LEN_W:0]     len_q, len_d;
  logic [LEN_W:0]     cnt_inc;
  logic [LEN_W:0]     len_first;

  logic               accept;
  logic [ACC_W:0]     sum;
  logic [ACC_W:0]     folded;

  // --------------------------------------------------------------------------
  // Folds a full-width (ACC_W+1) sum into the next {ovf, acc} pair.
  // The sticky overflow flag picks up the carry in both modes. In saturating
  // mode, once acc reaches all-ones, any later add either carries again or
  // adds zero. So acc stays clamped for the rest of the vector.
  // --------------------------------------------------------------------------
  function automatic logic [ACC_W:0] fold_sum(input logic [ACC_W:0] s,
                                              input logic           ovf_in);
    logic [ACC_W-1:0] v;
`ifdef ACC_SATURATE_EN
    v = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    v = s[ACC_W-1:0];
`endif
    return {ovf_in | s[ACC_W], v};
  endfunction

  // --------------------------------------------------------------------------
  // Handshake outputs depend only on registered state.
  // --------------------------------------------------------------------------
  assign prod_ready = run_q && (state_q != HOLD);
  assign acc_valid  = (state_q == HOLD);
  assign acc_out    = acc_q;
  assign acc_ovf    = ovf_q;

  assign accept    = prod_valid && prod_ready;
  assign sum       = {1'b0, acc_q} + (ACC_W+1)'(prod_in);
  assign folded    = fold_sum(sum, ovf_q);
  assign cnt_inc   = cnt_q + (LEN_W+1)'(1);
  assign len_first = (vec_len == '0) ? (LEN_W+1)'(1) : (LEN_W+1)'(vec_len);

  // --------------------------------------------------------------------------
  // Next-state logic. prod_in is only consumed on an accept, so garbage on
  // the bus while prod_valid or prod_ready is low never reaches acc.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // The first product starts a fresh vector. vec_len is latched here
          // only, so later changes to it do not affect this vector.
          acc_d   = ACC_W'(prod_in);
          ovf_d   = 1'b0;
          cnt_d   = (LEN_W+1)'(1);
          len_d   = len_first;
          state_d = (len_first == (LEN_W+1)'(1)) ? HOLD : ACCUM;
        end
      end

      ACCUM: begin
        if (accept) begin
          acc_d = folded[ACC_W-1:0];
          ovf_d = folded[ACC_W];
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        // The result stays on acc_out until the consumer takes it. The next
        // vector can only start after returning to IDLE, which forces at
        // least one non-accepting cycle between vectors.
        if (acc_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers. Reset clears everything and discards any partial vector.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator. Two instances share one stimulus stream:
// the default 40-bit accumulator and a 33-bit one, so overflow is exercised
// often. Expected results come from whole-vector arithmetic on the products
// and are queued per instance. Independent monitors pop and compare them on
// every output transfer.
module tb_product_accumulator;
  localparam int PROD_W  = 32;
  localparam int LEN_W   = 8;
  localparam int ACC_W_A = 40;
  localparam int ACC_W_B = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic [LEN_W-1:0]  vec_len;
  logic              acc_ready;

  logic               prod_ready_a, acc_valid_a, acc_ovf_a;
  logic [ACC_W_A-1:0] acc_out_a;
  logic               prod_ready_b, acc_valid_b, acc_ovf_b;
  logic [ACC_W_B-1:0] acc_out_b;

  product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W_A), .LEN_W(LEN_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready_a), .vec_len(vec_len), .acc_out(acc_out_a),
    .acc_ovf(acc_ovf_a), .acc_valid(acc_valid_a), .acc_ready(acc_ready));

  product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W_B), .LEN_W(LEN_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready_b), .vec_len(vec_len), .acc_out(acc_out_b),
    .acc_ovf(acc_ovf_b), .acc_valid(acc_valid_b), .acc_ready(acc_ready));

  int n_checks = 0;
  int n_pass   = 0;

  logic [ACC_W_A:0] exp_a[$];   // {ovf, acc}
  logic [ACC_W_B:0] exp_b[$];
  logic [31:0]      vec_q[$];

  // 0: acc_ready always high, 1: random, 2: held low
  int rdy_mode = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  // Reference result for one vector of width w, given the exact sum of all
  // its products. An overflow occurred exactly when the true total does not
  // fit in w bits.
  function automatic logic [64:0] model(input logic [63:0] total, input int w);
    logic [63:0] lim;
    logic        ovf;
    logic [63:0] v;
    lim = 64'd1 << w;
    ovf = (total >= lim);
`ifdef ACC_SATURATE_EN
    v = ovf ? (lim - 64'd1) : total;
`else
    v = total % lim;
`endif
    return {ovf, v};
  endfunction

  // Consumer: acc_ready changes just after the rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       acc_ready = 1'b1;
      1:       acc_ready = 1'($urandom_range(0, 1));
      default: acc_ready = 1'b0;
    endcase
  end

  // Monitors: sample on the falling edge, when outputs and acc_ready are
  // stable for the next rising edge.
  logic             hold_a = 1'b0, hold_b = 1'b0;
  logic [ACC_W_A:0] prev_a;
  logic [ACC_W_B:0] prev_b;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) hold_a = 1'b0;
    else if (acc_valid_a) begin
      if (hold_a) check("stable_a", 64'({acc_ovf_a, acc_out_a}), 64'(prev_a));
      if (acc_ready) begin
        hold_a = 1'b0;
        if (exp_a.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_a: got %0h expected none", acc_out_a);
        end else begin
          check("result_a", 64'({acc_ovf_a, acc_out_a}), 64'(exp_a.pop_front()));
        end
      end else begin
        hold_a = 1'b1;
        prev_a = {acc_ovf_a, acc_out_a};
      end
    end else hold_a = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n !== 1'b1) hold_b = 1'b0;
    else if (acc_valid_b) begin
      if (hold_b) check("stable_b", 64'({acc_ovf_b, acc_out_b}), 64'(prev_b));
      if (acc_ready) begin
        hold_b = 1'b0;
        if (exp_b.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_b: got %0h expected none", acc_out_b);
        end else begin
          check("result_b", 64'({acc_ovf_b, acc_out_b}), 64'(exp_b.pop_front()));
        end
      end else begin
        hold_b = 1'b1;
        prev_b = {acc_ovf_b, acc_out_b};
      end
    end else hold_b = 1'b0;
  end

  task automatic idle_bus();
    prod_valid = 1'b0;
    prod_in    = $urandom;
    vec_len    = 8'($urandom);
  endtask

  // Called at a falling edge. Presents one product and returns at the
  // falling edge after the rising edge that accepted it.
  task automatic put(input logic [31:0] p, input logic [7:0] vl);
    int g;
    g = 0;
    prod_valid = 1'b1;
    prod_in    = p;
    vec_len    = vl;
    while (prod_ready_a !== 1'b1) begin
      @(negedge clk);
      g++;
      if (g > 2000) begin
        $display("FAIL put_timeout: got prod_ready=%0b expected 1", prod_ready_a);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "stalled");
      end
    end
    @(negedge clk);
    idle_bus();
  endtask

  // Sends the products in vec_q as one vector of length field vl. The
  // expected result is queued before the last product goes out. The length
  // field is scrambled on every product after the first.
  task automatic send_vec(input logic [7:0] vl, input int gap_max);
    int          n;
    logic [63:0] total;
    logic [64:0] m;
    n     = (vl == 0) ? 1 : int'(vl);
    total = 64'd0;
    for (int i = 0; i < n; i++) total += 64'(vec_q[i]);
    m = model(total, ACC_W_A);
    exp_a.push_back({m[64], m[ACC_W_A-1:0]});
    m = model(total, ACC_W_B);
    exp_b.push_back({m[64], m[ACC_W_B-1:0]});
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      put(vec_q[i], (i == 0) ? vl : 8'($urandom));
    end
    vec_q.delete();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("drain_a", 64'(exp_a.size()), 64'd0);
    check("drain_b", 64'(exp_b.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] p;
    int          len;
    rst_n      = 1'b0;
    prod_valid = 1'b1;
    prod_in    = 32'hFFFF_FFFF;
    vec_len    = 8'd1;
    acc_ready  = 1'b1;

    // Reset with a valid product on the bus.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_prod_ready", 64'(prod_ready_a), 64'd0);
      check("rst_acc_valid",  64'(acc_valid_a),  64'd0);
      check("rst_acc_out",    64'(acc_out_a),    64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_prod_ready", 64'(prod_ready_a), 64'd1);
    check("post_rst_acc_valid",  64'(acc_valid_a),  64'd0);
    check("post_rst_acc_ovf",    64'(acc_ovf_a),    64'd0);
    idle_bus();
    @(negedge clk);

    // Four products back to back: 3+5+7+11.
    vec_q = '{32'd3, 32'd5, 32'd7, 32'd11};
    send_vec(8'd4, 0);
    check("lat_valid", 64'(acc_valid_a), 64'd1);
    check("sum26",     64'(acc_out_a),   64'd26);
    check("sum26_ovf", 64'(acc_ovf_a),   64'd0);
    @(negedge clk);
    check("valid_one_cycle", 64'(acc_valid_a), 64'd0);

    // Zero length field behaves as a single-product vector.
    vec_q = '{32'hFFFE_0001};
    send_vec(8'd0, 0);
    check("len0_out", 64'(acc_out_a), 64'h00_FFFE_0001);
    @(negedge clk);

    // Gapped valids at cycles 0, 2, 5, and a stalled consumer.
    rdy_mode = 2;
    @(negedge clk);
    begin
      logic [64:0] m;
      m = model(64'd600, ACC_W_A); exp_a.push_back({m[64], m[ACC_W_A-1:0]});
      m = model(64'd600, ACC_W_B); exp_b.push_back({m[64], m[ACC_W_B-1:0]});
    end
    put(32'd100, 8'd3);
    @(negedge clk);
    put(32'd200, 8'd9);
    @(negedge clk);
    @(negedge clk);
    put(32'd300, 8'd1);
    for (int i = 0; i < 4; i++) begin
      check("stall_prod_ready", 64'(prod_ready_a), 64'd0);
      check("stall_valid",      64'(acc_valid_a),  64'd1);
      check("stall_out",        64'(acc_out_a),    64'd600);
      @(negedge clk);
    end
    rdy_mode = 0;
    drain();

    // Three all-ones products overflow the 33-bit instance.
    vec_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    send_vec(8'd3, 0);
`ifdef ACC_SATURATE_EN
    check("ovf33_out", 64'(acc_out_b), 64'h1_FFFF_FFFF);
`else
    check("ovf33_out", 64'(acc_out_b), 64'h0_FFFF_FFFD);
`endif
    check("ovf33_flag", 64'(acc_ovf_b), 64'd1);
    check("ovf40_out",  64'(acc_out_a), 64'h2_FFFF_FFFD);
    check("ovf40_flag", 64'(acc_ovf_a), 64'd0);
    @(negedge clk);

    // Reset in the middle of a vector, then a fresh vector.
    put(32'd1000, 8'd4);
    put(32'd2000, 8'd4);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_valid", 64'(acc_valid_a), 64'd0);
    check("abort_ready", 64'(prod_ready_a), 64'd0);
    check("abort_out",   64'(acc_out_a),   64'd0);
    check("abort_ovf_b", 64'(acc_ovf_b),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    vec_q = '{32'd10, 32'd20};
    send_vec(8'd2, 0);
    check("after_abort", 64'(acc_out_a), 64'd30);
    @(negedge clk);

    // Randomized vectors with gaps and a random consumer.
    rdy_mode = 1;
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(0, 9);
      for (int i = 0; i < ((len == 0) ? 1 : len); i++) begin
        case ($urandom_range(0, 3))
          0:       p = 32'hFFFF_FFFF;
          1:       p = $urandom_range(0, 255);
          default: p = $urandom;
        endcase
        vec_q.push_back(p);
      end
      send_vec(8'(len), 2);
    end
    // Longest vector: the counter must reach 255 without wrapping.
    for (int i = 0; i < 255; i++) vec_q.push_back($urandom);
    send_vec(8'd255, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
